prover_compute_v_shiftq: RTL and testbench
==========================================

# prover_compute_v_shiftq

Parametrised shift-queue for the prover's V-evaluation datapath: a DEPTH-deep, WIDTH-bit register chain that supports parallel load, serial push at the tail, and pop of one element (normal) or two elements (skip) from the head. An occupancy counter tracks how many entries are live. The block replaces hand-chained single shift elements in the compute_v stage. All outputs are registered.

## Interface
Parameters:
- WIDTH, default `F_NBITS: element width in bits.
- DEPTH, default 8: number of elements. Legal values are 2 or more.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  input  1  clock. One clock; all state changes on its rising edge.
- rst  input  1  reset. Asynchronous and active-high.
- en  input  1  global enable. When 0, all state holds and all strobes are ignored.
- load  input  1  parallel load strobe.
- in_load  input  DEPTH*WIDTH  parallel load data; element i is bits [i*WIDTH +: WIDTH].
- push  input  1  serial push strobe.
- in_push  input  WIDTH  push data.
- pop  input  1  remove entries from the head.
- skip  input  1  qualifies pop: remove two entries instead of one.
- head  output  WIDTH  element 0.
- head_valid  output  1  count != 0.
- all_out  output  DEPTH*WIDTH  all elements, same packing as in_load.
- count  output  CNT_W  number of live entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- push_ok  output  1  combinational: a push issued this cycle will be accepted.

## Operation
- Storage: elements e[0..DEPTH-1]. Live entries are e[0..count-1]. Dead entries read as 0.
- Priority when en=1: load > (pop/skip combined with push). When en=0, nothing changes.
- load=1:
  - e[i] <= in_load element i for every i; count <= DEPTH.
  - pop, skip and push are ignored in the same cycle.
- Removal amount r:
  - pop=0 gives r = 0. skip without pop has no effect.
  - pop=1, skip=0 gives r = min(1, count).
  - pop=1, skip=1 gives r = min(2, count).
  - Pop while empty gives r = 0 and is a legal no-op.
- Shift: e[i] <= e[i+r] for i+r < DEPTH; vacated tail elements <= 0.
- Push acceptance: push_ok = en & ~load & (count - r < DEPTH). A push while push_ok=0 is dropped and state is unchanged by it.
- Accepted push: the element at index count - r (post-shift position) <= in_push, overriding the zero fill.
- Count update: count <= count - r + (push accepted). The result never exceeds DEPTH and never underflows.
- Simultaneous pop and push with count=1 and r=1: the queue ends with e[0] = in_push and count = 1.

## Timing
- Reset (asynchronous assert, active-high):
  - all elements 0, count 0, head 0, all_out 0, head_valid 0, empty 1, full 0.
  - push_ok follows its equation: 1 once rst is released and en=1, load=0.
- Mid-operation reset discards all entries immediately, with no wait for a clock edge.
- Latency: every strobe takes effect at the next rising edge. head, all_out, count, empty, full and head_valid reflect the new state one cycle after the strobe.
- push_ok is the only combinational output, valid within the same cycle as its inputs.
- No handshake stall: the block accepts one operation set per enabled cycle, back-to-back, with no bubbles.
- Full plus push plus pop: r=1 frees a slot, so the push is accepted, count stays DEPTH, and full stays 1.
- Full plus push without pop: the push is dropped; count and contents are unchanged.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset and fill:
  - Stimulus: assert rst mid-stream while count=3.
  - Required: on the same cycle count=0, empty=1, head=0, all_out=0.
  - Stimulus: release rst, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: count 1 through 4, full=1 after the fourth push, all_out elements = {0x11,0x22,0x33,0x44}.
- Parallel load with priority:
  - Stimulus: load {1,2,3,4} in the same cycle as pop=1 and push=1 with in_push=0x99.
  - Required: next cycle count=4, head=1; the pop and push have no effect.
- Pop and skip:
  - Stimulus: from {1,2,3,4}, pop; then pop with skip=1.
  - Required: after the pop, head=2 and count=3. After the skip-pop, head=4, count=1, elements {4,0,0,0}.
  - Stimulus: skip-pop again with count=1.
  - Required: count=0, empty=1.
- Full boundary:
  - Stimulus: full queue {1,2,3,4}, push 0x55 with pop=0.
  - Required: push_ok=0 and the state is unchanged.
  - Stimulus: push 0x55 with pop=1.
  - Required: push_ok=1, elements {2,3,4,0x55}, count=4.
- Enable gating and empty pop:
  - Stimulus: with en=0, hold load, push and pop active for 3 cycles.
  - Required: the state is unchanged.
  - Stimulus: with en=1 on an empty queue, pop=1 and skip=1.
  - Required: count stays 0. A push in the same cycle gives e[0] = in_push and count=1.

Source files
------------

// File: rtl/prover_compute_v_shiftq.sv
// DEPTH-deep shift queue for the compute_v stage: parallel load, tail push,
// and single/double pop from the head, with a registered occupancy count.
`ifndef F_NBITS
`define F_NBITS 32
`endif

module prover_compute_v_shiftq #(
  parameter int WIDTH = `F_NBITS,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [DEPTH*WIDTH-1:0] in_load,
  input  logic                   push,
  input  logic [WIDTH-1:0]       in_push,
  input  logic                   pop,
  input  logic                   skip,
  output logic [WIDTH-1:0]       head,
  output logic                   head_valid,
  output logic [DEPTH*WIDTH-1:0] all_out,
  output logic [CNT_W-1:0]       count,
  output logic                   empty,
  output logic                   full,
  output logic                   push_ok
);

  logic [WIDTH-1:0] e      [DEPTH];
  logic [WIDTH-1:0] e_nxt  [DEPTH];
  // Two zero slots past the tail let every shift amount index in range.
  logic [WIDTH-1:0] ext    [DEPTH+2];
  logic [CNT_W-1:0] r;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] count_nxt;
  logic             push_acc;

  always_comb begin
    r = '0;
    if (pop) begin
      if (skip && count >= CNT_W'(2)) r = CNT_W'(2);
      else if (count != '0)            r = CNT_W'(1);
    end
  end

  // Post-shift occupancy; r never exceeds count, so this cannot wrap.
  assign base     = count - r;
  assign push_ok  = en & ~load & (base < CNT_W'(DEPTH));
  assign push_acc = push_ok & push;

  always_comb begin
    for (int i = 0; i < DEPTH + 2; i++) ext[i] = '0;
    for (int i = 0; i < DEPTH; i++)     ext[i] = e[i];

    count_nxt = count;
    for (int i = 0; i < DEPTH; i++) e_nxt[i] = e[i];

    if (load) begin
      for (int i = 0; i < DEPTH; i++) e_nxt[i] = in_load[i*WIDTH +: WIDTH];
      count_nxt = CNT_W'(DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        case (r)
          CNT_W'(1): e_nxt[i] = ext[i+1];
          CNT_W'(2): e_nxt[i] = ext[i+2];
          default:   e_nxt[i] = ext[i];
        endcase
        if (push_acc && CNT_W'(i) == base) e_nxt[i] = in_push;
      end
      count_nxt = base + CNT_W'(push_acc);
    end
  end

  // NOTE: the storage array is reset too, so dead entries read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) e[i] <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) e[i] <= e_nxt[i];
      count      <= count_nxt;
      head       <= e_nxt[0];
      head_valid <= (count_nxt != '0);
      empty      <= (count_nxt == '0);
      full       <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign all_out[g*WIDTH +: WIDTH] = e[g];
  end

endmodule

// File: tb/tb_prover_compute_v_shiftq.sv
// Randomised and directed bench for prover_compute_v_shiftq (WIDTH=8, DEPTH=4)
// against a queue-based reference model.
module tb_prover_compute_v_shiftq;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0, load = 1'b0, push = 1'b0, pop = 1'b0, skip = 1'b0;
  logic [D*W-1:0] in_load = '0;
  logic [W-1:0]   in_push = '0;
  logic [W-1:0]   head;
  logic           head_valid, empty, full, push_ok;
  logic [D*W-1:0] all_out;
  logic [CW-1:0]  count;

  prover_compute_v_shiftq #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .in_load(in_load),
    .push(push), .in_push(in_push), .pop(pop), .skip(skip),
    .head(head), .head_valid(head_valid), .all_out(all_out),
    .count(count), .empty(empty), .full(full), .push_ok(push_ok)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_all();
    logic [31:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[i*W +: W] = q[i];
    return v;
  endfunction

  function automatic int removal();
    int n = q.size();
    if (!pop) return 0;
    if (skip) return (n < 2) ? n : 2;
    return (n < 1) ? n : 1;
  endfunction

  function automatic logic exp_push_ok();
    return en && !load && (q.size() - removal() < D);
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_head"}, 32'(head), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check({tag, "_head_valid"}, 32'(head_valid), 32'(q.size() != 0));
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(q.size() == D));
    check({tag, "_all_out"}, all_out, exp_all());
  endtask

  // Called at a falling edge: drive, check push_ok, advance model, check state.
  task automatic step(input string tag, input logic e_i, input logic l_i,
                      input logic [D*W-1:0] li, input logic p_i, input logic [W-1:0] pi,
                      input logic po_i, input logic sk_i);
    logic ok;
    int   r;
    en = e_i; load = l_i; in_load = li; push = p_i; in_push = pi; pop = po_i; skip = sk_i;
    #1;
    ok = exp_push_ok();
    r  = removal();
    check({tag, "_push_ok"}, 32'(push_ok), 32'(ok));
    if (en) begin
      if (load) begin
        q.delete();
        for (int i = 0; i < D; i++) q.push_back(li[i*W +: W]);
      end else begin
        for (int i = 0; i < r; i++) void'(q.pop_front());
        if (push && ok) q.push_back(pi);
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  localparam logic [D*W-1:0] L1234 = 32'h04030201;

  initial begin
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;

    step("pre1", 1, 0, '0, 1, 8'hA1, 0, 0);
    step("pre2", 1, 0, '0, 1, 8'hA2, 0, 0);
    step("pre3", 1, 0, '0, 1, 8'hA3, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_empty", 32'(empty), 1);
    check("async_rst_head", 32'(head), 0);
    check("async_rst_all", all_out, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    step("fill1", 1, 0, '0, 1, 8'h11, 0, 0);
    step("fill2", 1, 0, '0, 1, 8'h22, 0, 0);
    step("fill3", 1, 0, '0, 1, 8'h33, 0, 0);
    step("fill4", 1, 0, '0, 1, 8'h44, 0, 0);
    check("fill_all_const", all_out, 32'h44332211);

    step("load_prio", 1, 1, L1234, 1, 8'h99, 1, 0);
    check("load_head_const", 32'(head), 1);
    step("pop1", 1, 0, '0, 0, 8'h00, 1, 0);
    step("skip_pop", 1, 0, '0, 0, 8'h00, 1, 1);
    check("skip_all_const", all_out, 32'h00000004);
    step("skip_last", 1, 0, '0, 0, 8'h00, 1, 1);

    step("reload", 1, 1, L1234, 0, 8'h00, 0, 0);
    step("full_drop", 1, 0, '0, 1, 8'h55, 0, 0);
    step("full_poppush", 1, 0, '0, 1, 8'h55, 1, 0);
    check("full_poppush_const", all_out, 32'h55040302);

    for (int i = 0; i < 3; i++) step("en_off", 0, 1, 32'hDEADBEEF, 1, 8'h66, 1, 1);

    step("drain", 1, 0, '0, 0, 8'h00, 1, 1);
    step("drain2", 1, 0, '0, 0, 8'h00, 1, 1);
    step("empty_pop", 1, 0, '0, 0, 8'h00, 1, 1);
    step("empty_poppush", 1, 0, '0, 1, 8'h77, 1, 1);
    step("one_poppush", 1, 0, '0, 1, 8'h78, 1, 0);
    check("one_poppush_const", all_out, 32'h00000078);

    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
